// File: rtl/raddr_arbiter_pkg.sv
// Shared definitions for the AXI address-channel arbiters: FSM encodings,
// channel field widths and the per-requester outstanding-count helper.
package raddr_arbiter_pkg;

    localparam int ADDR_W  = 64;
    localparam int ARLEN_W = 8;
    localparam int CNT_W   = 4;

    // One-hot so a stray encoding is obvious on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'h1,
        ST_SEND = 2'h2
    } state_t;

    // Same-index issue and completion in one cycle cancel out.
    function automatic logic [CNT_W-1:0] cnt_step(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] res;
        res = cnt;
        if (inc && !dec) res = cnt + CNT_W'(1);
        if (dec && !inc) res = cnt - CNT_W'(1);
        return res;
    endfunction

endpackage

// File: rtl/raddr_arbiter_if.sv
// Requester-side AR bundle plus the shell-side AXI AR channel and R-channel
// snoop, grouped so the arbiter and its environment share one declaration.
interface raddr_arbiter_if
    import raddr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);

    logic [NREQ*ADDR_W-1:0]  req_araddr;
    logic [NREQ*ARLEN_W-1:0] req_arlen;
    logic [NREQ-1:0]         req_arvalid;
    logic [NREQ-1:0]         req_arready;

    logic [ADDR_W-1:0]       m_axi_araddr;
    logic [ARLEN_W-1:0]      m_axi_arlen;
    logic [ID_W-1:0]         m_axi_arid;
    logic                    m_axi_arvalid;
    logic                    m_axi_arready;

    logic                    m_axi_rvalid;
    logic                    m_axi_rready;
    logic                    m_axi_rlast;
    logic [ID_W-1:0]         m_axi_rid;

    // Handshake: a transfer completes in any cycle where valid and ready are
    // both high at the rising clock edge. valid never waits on ready; ready may
    // depend on valid (req_arready does), and a raised m_axi_arvalid with its
    // payload is held until m_axi_arready is seen.
    modport master (
        input  req_araddr, req_arlen, req_arvalid,
        output req_arready,
        output m_axi_araddr, m_axi_arlen, m_axi_arid, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rvalid, m_axi_rready, m_axi_rlast, m_axi_rid
    );

    modport slave (
        output req_araddr, req_arlen, req_arvalid,
        input  req_arready,
        input  m_axi_araddr, m_axi_arlen, m_axi_arid, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rvalid, m_axi_rready, m_axi_rlast, m_axi_rid
    );

endinterface

// File: rtl/raddr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first eligible requester after
// last_grant, wrapping modulo NREQ.
module rr_pick
    import raddr_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  elig,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = 0;
        pos_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = int'(last_grant) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            pos_idx = IDX_W'(pos);
            if (!any && elig[pos_idx]) begin
                any               = 1'b1;
                grant_oh[pos_idx] = 1'b1;
                grant_idx         = pos_idx;
            end
        end
    end

endmodule

// File: rtl/raddr_arbiter.sv
// Round-robin arbiter sharing one AXI4 AR channel among NREQ read engines,
// tagging bursts with the requester index and throttling on open-burst count.
module raddr_arbiter
    import raddr_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int ID_W      = 2,
    parameter int MAX_OUTST = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    raddr_arbiter_if.master       bus,
    output logic                  busy,
    output logic                  err_underflow,
    output state_t                dbg_state,
    output logic [NREQ*CNT_W-1:0] dbg_outst
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  araddr_q;
    logic [ARLEN_W-1:0] arlen_q;
    logic [ID_W-1:0]    arid_q;
    logic [ID_W-1:0]    last_grant_q;
    logic [CNT_W-1:0]   outst_q [NREQ];
    logic               err_q;

    logic [NREQ-1:0]    elig;
    logic [NREQ-1:0]    grant_oh;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               grant_fire;
    logic               ar_fire;
    logic               r_done;
    logic [NREQ-1:0]    inc_vec;
    logic [NREQ-1:0]    dec_vec;
    logic               underflow;
    logic               any_open;
    logic [ADDR_W-1:0]  sel_addr;
    logic [ARLEN_W-1:0] sel_len;

    // Eligibility looks at the registered count, so a freed slot is usable
    // the cycle after the completing rlast beat.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = bus.req_arvalid[i] && (outst_q[i] < CNT_W'(MAX_OUTST));
        end
    end

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (ID_W)
    ) u_rr_pick (
        .elig       (elig),
        .last_grant (last_grant_q),
        .grant_oh   (grant_oh),
        .grant_idx  (grant_idx),
        .any        (grant_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                sel_addr = bus.req_araddr[i*ADDR_W +: ADDR_W];
                sel_len  = bus.req_arlen[i*ARLEN_W +: ARLEN_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_fire = 1'b0;
        ar_fire    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    grant_fire = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.m_axi_arready) begin
                    ar_fire = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arid_q       <= '0;
            last_grant_q <= ID_W'(NREQ - 1);
        end else begin
            state_q <= state_d;
            if (grant_fire) begin
                araddr_q <= sel_addr;
                arlen_q  <= sel_len;
                arid_q   <= grant_idx;
            end
            if (ar_fire) last_grant_q <= arid_q;
        end
    end

    // A completion for an empty counter or an out-of-range rid matches no
    // dec_vec bit and is flagged instead of applied.
    assign r_done = bus.m_axi_rvalid && bus.m_axi_rready && bus.m_axi_rlast;

    always_comb begin
        inc_vec   = '0;
        dec_vec   = '0;
        any_open  = 1'b0;
        dbg_outst = '0;
        for (int i = 0; i < NREQ; i++) begin
            inc_vec[i] = ar_fire && (arid_q == ID_W'(i));
            dec_vec[i] = r_done && (bus.m_axi_rid == ID_W'(i)) && (outst_q[i] != '0);
            any_open   = any_open || (outst_q[i] != '0);
            dbg_outst[i*CNT_W +: CNT_W] = outst_q[i];
        end
        underflow = r_done && (dec_vec == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) outst_q[i] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                outst_q[i] <= cnt_step(outst_q[i], inc_vec[i], dec_vec[i]);
            end
            if (underflow) err_q <= 1'b1;
        end
    end

    assign bus.req_arready   = grant_fire ? grant_oh : '0;
    assign bus.m_axi_arvalid = (state_q == ST_SEND);
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = arlen_q;
    assign bus.m_axi_arid    = arid_q;
    assign busy              = (state_q != ST_IDLE) || any_open;
    assign err_underflow     = err_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_raddr_arbiter.sv
// Bench for raddr_arbiter: vector table, directed multi-cycle corners and a
// randomized run against a transaction-level reference model.
module tb_raddr_arbiter;
    import raddr_arbiter_pkg::*;

    localparam int NREQ      = 4;
    localparam int ID_W      = 2;
    localparam int MAX_OUTST = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  busy;
    logic                  err_underflow;
    state_t                dbg_state;
    logic [NREQ*CNT_W-1:0] dbg_outst;

    int errors = 0;
    int checks = 0;

    logic [63:0] addr_tab [NREQ];
    logic [7:0]  len_tab  [NREQ];

    raddr_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

    raddr_arbiter #(
        .NREQ      (NREQ),
        .ID_W      (ID_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.master),
        .busy          (busy),
        .err_underflow (err_underflow),
        .dbg_state     (dbg_state),
        .dbg_outst     (dbg_outst)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic set_req(input logic [NREQ-1:0] v);
        bus.req_arvalid = v;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_araddr[i*64 +: 64] = addr_tab[i];
            bus.req_arlen[i*8 +: 8]    = len_tab[i];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req('0);
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rready  = 1'b0;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rid     = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- driver ----------------
    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic cycle(input logic [NREQ-1:0] v, input logic ar, input logic rv,
                         input logic rr, input logic rl, input logic [ID_W-1:0] rid);
        @(posedge clk);
        #1;
        set_req(v);
        bus.m_axi_arready = ar;
        bus.m_axi_rvalid  = rv;
        bus.m_axi_rready  = rr;
        bus.m_axi_rlast   = rl;
        bus.m_axi_rid     = rid;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] cnt_of(input int i);
        return 64'(dbg_outst[i*CNT_W +: CNT_W]);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [NREQ-1:0] valid;
        logic            arready;
        logic [NREQ-1:0] exp_rdy;
        logic            exp_av;
        logic [ID_W-1:0] exp_id;
    } vec_t;

    vec_t vecs [14];

    // ---------------- scoreboard model ----------------
    int          m_cnt [NREQ];
    bit          m_open;
    bit          m_err;
    int          m_id;
    int          m_last;
    logic [63:0] m_addr;
    logic [7:0]  m_len;
    logic [63:0] exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_open = 0;
        m_err  = 0;
        m_id   = 0;
        m_last = NREQ - 1;
        exp_q.delete();
    endtask

    task automatic model_cycle();
        int g;
        int busy_exp;
        logic [NREQ-1:0] exp_rdy;
        logic [63:0] exp_word;
        g = -1;
        if (!m_open) begin
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (m_last + k) % NREQ;
                if (g < 0 && bus.req_arvalid[i] && m_cnt[i] < MAX_OUTST) g = i;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        busy_exp = m_open ? 1 : 0;
        for (int i = 0; i < NREQ; i++) if (m_cnt[i] != 0) busy_exp = 1;

        chk("rnd_rdy", 64'(bus.req_arready), 64'(exp_rdy));
        chk("rnd_arvalid", 64'(bus.m_axi_arvalid), 64'(m_open));
        chk("rnd_busy", 64'(busy), 64'(busy_exp));
        chk("rnd_err", 64'(err_underflow), 64'(m_err));
        for (int i = 0; i < NREQ; i++) chk("rnd_outst", cnt_of(i), 64'(m_cnt[i]));
        if (m_open && bus.m_axi_arready) begin
            exp_word = exp_q.pop_front();
            chk("rnd_araddr", bus.m_axi_araddr, exp_word);
            chk("rnd_arlen", 64'(bus.m_axi_arlen), 64'(m_len));
            chk("rnd_arid", 64'(bus.m_axi_arid), 64'(m_id));
        end

        if (bus.m_axi_rvalid && bus.m_axi_rready && bus.m_axi_rlast) begin
            if (m_cnt[bus.m_axi_rid] == 0) m_err = 1;
            else m_cnt[bus.m_axi_rid]--;
        end
        if (m_open && bus.m_axi_arready) begin
            m_cnt[m_id]++;
            m_last = m_id;
            m_open = 0;
        end
        if (g >= 0) begin
            m_open = 1;
            m_id   = g;
            m_addr = bus.req_araddr[g*64 +: 64];
            m_len  = bus.req_arlen[g*8 +: 8];
            exp_q.push_back(m_addr);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n_ar;
        logic [63:0] held_addr;

        addr_tab[0] = 64'h0000_0000_0000_0A00; len_tab[0] = 8'h0F;
        addr_tab[1] = 64'h0000_0000_0000_1000; len_tab[1] = 8'h02;
        addr_tab[2] = 64'hFFFF_FFFF_FFFF_F000; len_tab[2] = 8'hFF;
        addr_tab[3] = 64'h8000_0000_1234_5678; len_tab[3] = 8'h00;

        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd1};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0100, 1'b0, 2'd0};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd2};
        vecs[6]  = '{4'b1111, 1'b1, 4'b1000, 1'b0, 2'd0};
        vecs[7]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd3};
        vecs[8]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
        vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[11] = '{4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0};
        vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1};
        vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_rdy", 64'(bus.req_arready), 64'd0);
        chk("rst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        chk("rst_araddr", bus.m_axi_araddr, 64'd0);
        chk("rst_arlen", 64'(bus.m_axi_arlen), 64'd0);
        chk("rst_arid", 64'(bus.m_axi_arid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_underflow), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'h1);
        chk("rst_outst", 64'(dbg_outst), 64'd0);

        // Round-robin fairness then a lone requester 1
        for (int v = 0; v < 14; v++) begin
            cycle(vecs[v].valid, vecs[v].arready, 1'b0, 1'b0, 1'b0, '0);
            chk("tab_rdy", 64'(bus.req_arready), 64'(vecs[v].exp_rdy));
            chk("tab_arvalid", 64'(bus.m_axi_arvalid), 64'(vecs[v].exp_av));
            if (vecs[v].exp_av) begin
                chk("tab_arid", 64'(bus.m_axi_arid), 64'(vecs[v].exp_id));
                chk("tab_araddr", bus.m_axi_araddr, addr_tab[vecs[v].exp_id]);
                chk("tab_arlen", 64'(bus.m_axi_arlen), 64'(len_tab[vecs[v].exp_id]));
            end
        end
        chk("tab_outst0", cnt_of(0), 64'd2);
        chk("tab_outst1", cnt_of(1), 64'd2);
        chk("tab_outst2", cnt_of(2), 64'd1);
        chk("tab_outst3", cnt_of(3), 64'd1);

        // Throttle at MAX_OUTST, then release by one rlast
        do_reset();
        n_ar = 0;
        for (int c = 0; c < 30; c++) begin
            cycle(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            if (bus.m_axi_arvalid && bus.m_axi_arready) n_ar++;
        end
        chk("thr_count", 64'(n_ar), 64'(MAX_OUTST));
        chk("thr_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        chk("thr_rdy", 64'(bus.req_arready), 64'd0);
        chk("thr_outst0", cnt_of(0), 64'(MAX_OUTST));
        chk("thr_busy", 64'(busy), 64'd1);
        cycle(4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
        chk("thr_rdy_rlast", 64'(bus.req_arready), 64'd0);
        cycle(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("thr_rdy_after", 64'(bus.req_arready), 64'b0001);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("thr_9th_arvalid", 64'(bus.m_axi_arvalid), 64'd1);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("thr_outst_end", cnt_of(0), 64'(MAX_OUTST));

        // Back-pressure: payload held while arready is low, new requests wait
        do_reset();
        cycle(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("bp_rdy", 64'(bus.req_arready), 64'b0100);
        held_addr = addr_tab[2];
        for (int c = 0; c < 5; c++) begin
            addr_tab[2] = {$urandom, $urandom};
            cycle(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            chk("bp_rdy_stall", 64'(bus.req_arready), 64'd0);
            chk("bp_arvalid", 64'(bus.m_axi_arvalid), 64'd1);
            chk("bp_araddr", bus.m_axi_araddr, held_addr);
            chk("bp_arlen", 64'(bus.m_axi_arlen), 64'(len_tab[2]));
            chk("bp_arid", 64'(bus.m_axi_arid), 64'd2);
        end
        addr_tab[2] = held_addr;
        cycle(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("bp_issue", 64'(bus.m_axi_arvalid), 64'd1);
        chk("bp_issue_rdy", 64'(bus.req_arready), 64'd0);
        cycle(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("bp_next_grant", 64'(bus.req_arready), 64'b1000);

        // Same-cycle issue and completion on id 2; underflow on id 3
        do_reset();
        cycle(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        cycle(4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2);
        chk("sim_rdy", 64'(bus.req_arready), 64'b0100);
        chk("sim_no_rready", cnt_of(2), 64'd1);
        cycle(4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
        chk("sim_arvalid", 64'(bus.m_axi_arvalid), 64'd1);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("sim_outst2", cnt_of(2), 64'd1);
        chk("sim_err_clear", 64'(err_underflow), 64'd0);
        cycle(4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("uf_err", 64'(err_underflow), 64'd1);
        chk("uf_outst", 64'(dbg_outst), 64'h0100);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("uf_sticky", 64'(err_underflow), 64'd1);

        // Asynchronous reset during SEND
        do_reset();
        cycle(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("ar_pre_arvalid", 64'(bus.m_axi_arvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_state", 64'(dbg_state), 64'h1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("ar_first_prio", 64'(bus.req_arready), 64'b0001);

        // Randomized traffic against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                addr_tab[i] = {$urandom, $urandom};
                len_tab[i]  = 8'($urandom);
            end
            cycle(NREQ'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  ID_W'($urandom_range(0, NREQ - 1)));
            model_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/raddr_arbiter.md
# raddr_arbiter

Round-robin arbiter that shares one AXI4 read-address channel among `NREQ` local read engines, such as tile fetchers. It tags each issued burst with the requester index on `m_axi_arid`. It tracks outstanding bursts per requester by snooping R-channel `rlast` beats. It throttles any requester that reaches `MAX_OUTST` open bursts. It sits between the per-engine AR generators and the shell's AXI master port.

## Interface
- `NREQ`, default 4: number of requesters, 2..4.
- `ID_W`, default 2: width of `m_axi_arid` and `m_axi_rid`; must satisfy 2^ID_W >= NREQ.
- `MAX_OUTST`, default 8: maximum open bursts per requester, 1..15.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_araddr`, in, NREQ*64: packed burst addresses; requester i occupies bits [64i+63:64i].
- `req_arlen`, in, NREQ*8: packed AXI burst lengths (beats−1).
- `req_arvalid`, in, NREQ: request valid per requester.
- `req_arready`, out, NREQ: request accepted; one-hot or zero.
- `m_axi_araddr`, out, 64: issued address.
- `m_axi_arlen`, out, 8: issued length.
- `m_axi_arid`, out, ID_W: index of the granted requester.
- `m_axi_arvalid`, out, 1: AR valid.
- `m_axi_arready`, in, 1: AR ready.
- `m_axi_rvalid`, in, 1: R-channel snoop.
- `m_axi_rready`, in, 1: R-channel snoop.
- `m_axi_rlast`, in, 1: R-channel snoop.
- `m_axi_rid`, in, ID_W: R-channel snoop.
- `busy`, out, 1: high when the FSM is not in IDLE or any outstanding count is nonzero.
- `err_underflow`, out, 1: sticky flag; cleared only by reset.

## Operation
- **Eligibility.** Requester i is eligible when `req_arvalid[i]` is high and `outst[i] < MAX_OUTST`.
- **FSM.** One-hot, two states: IDLE='h1, SEND='h2.
- **IDLE.**
  - If any requester is eligible, pick g by round-robin. The search starts at `last_grant+1` and wraps modulo NREQ.
  - `req_arready[g]` is driven combinationally high in this cycle, so the handshake completes here.
  - Capture `req_araddr[g]`, `req_arlen[g]` and g into the output registers.
  - Next state is SEND.
  - If no requester is eligible, all `req_arready` are 0 and the FSM stays in IDLE.
- **SEND.**
  - `m_axi_arvalid` is 1. Address, length and ID are held stable.
  - All `req_arready` are 0.
  - On `m_axi_arready`: increment `outst[g]`, set `last_grant <= g`, return to IDLE.
- **Completion.** When `m_axi_rvalid & m_axi_rready & m_axi_rlast` are all high, decrement `outst[m_axi_rid]`.
  - Inc and dec on the same index in the same cycle leave the count unchanged.
  - Inc and dec on different indices in the same cycle are both applied.
- **Underflow.** A completion for an index whose count is 0, or for an rid >= NREQ, is ignored and sets `err_underflow`.
- **Width rules.**
  - Each count is 4 bits wide and saturates by construction, because eligibility prevents exceeding `MAX_OUTST`.
  - The address passes through unmodified; there is no arithmetic on it.

## Timing
- **Reset values.**
  - All outputs are 0.
  - FSM is in IDLE; all `outst` counts are 0.
  - `last_grant = NREQ-1`, so requester 0 has first priority after reset.
- **Latency.** `m_axi_arvalid` rises one cycle after the `req_arready` handshake.
- **Throughput.** Peak issue rate is one AR every 2 cycles (IDLE → SEND → IDLE with immediate `arready`).
- **Stall.** `m_axi_arready` low holds SEND indefinitely. Requests arriving meanwhile wait; none is dropped.
- **Throttle timing.** A requester at `MAX_OUTST` becomes eligible in the cycle after the decrementing `rlast` beat, because eligibility uses the registered count.
- **Reset mid-operation.** `m_axi_arvalid`, the counts and the flags clear immediately (asynchronously). An in-flight burst is abandoned; the system resets the AXI slave concurrently.

## Structure
- **Shared package.** Holds the state encodings (IDLE='h1, SEND='h2) and the `m_axi_arlen` width constant, for reuse by the future write-address arbiter.
- **Sub-module `rr_pick`.** Combinational. Inputs: eligibility mask, `last_grant`. Outputs: one-hot grant, encoded index, `any`.
- **Top level.** Holds the FSM, output registers and counter array.

## Test plan
- **Single requester.** Req 1 valid with addr 0x1000, len 2, `arready` tied high → `req_arready[1]` pulses in cycle 0; in cycle 1 `arvalid`=1, `araddr`=0x1000, `arlen`=2, `arid`=1; `outst[1]`=1.
- **Round-robin fairness.** All 4 requesters held valid with `arready`=1 → grant order 0,1,2,3,0 with `arid` matching; one AR every 2 cycles.
- **Throttle.** Req 0 only, `MAX_OUTST`=8, no R traffic → exactly 8 ARs issue, then `arvalid` stays 0. One `rlast` with rid=0 → a 9th AR issues 2 cycles later.
- **Back-pressure.** `arready` held low for 5 cycles in SEND → address, length and ID are stable, no `req_arready` asserts, and the request issues on the first cycle `arready` is high.
- **Simultaneous events.** AR handshake for id 2 in the same cycle as `rlast` for rid 2 → `outst[2]` is unchanged. An `rlast` with rid=3 while `outst[3]`=0 → `err_underflow`=1 and the counts are unchanged.
- **Async reset mid-burst.** Assert `rst_n`=0 during SEND → `arvalid` falls immediately and `busy`=0. After release, requester 0 has first priority.
